load_word_buffer: RTL and testbench
===================================

Name: load_word_buffer

Overview:
- Parametrised successor to the 4-letter switch loader.
- Collects NUM_SYMS symbols from switches, one per debounced button press. Each symbol is validated against MAX_SYM, written into an internal buffer and presented as a packed word for the encryption/decryption stages.
- Adds rising-edge button detection, a backspace button, an invalid-entry flag, a fill index and a held word_valid.

Parameters:
- SYM_W, 5, bits per symbol.
- NUM_SYMS, 4, symbols per word; legal range 2..16.
- MAX_SYM, 26, largest legal symbol value; must be < 2**SYM_W.
- IDX_W, $clog2(NUM_SYMS+1), index width (derived, not overridable).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- btn_load  in  1  load button level (already debounced/synchronised)
- btn_back  in  1  backspace button level (already debounced/synchronised)
- sw_in  in  SYM_W  switch value
- sw_echo  out  SYM_W  registered copy of sw_in for display
- word_out  out  NUM_SYMS*SYM_W  packed buffer; slot 0 at bits [SYM_W-1:0]
- word_valid  out  1  high while all NUM_SYMS slots are filled
- load_pulse  out  1  one-cycle strobe on every accepted load, and on re-arm from FULL
- err_invalid  out  1  one-cycle strobe when a load press carries sw_in > MAX_SYM
- fill_idx  out  IDX_W  number of slots currently filled (0..NUM_SYMS)

Behaviour:
- Reset (rst==0 at posedge clk):
  - state=LOAD, all slots=0, fill_idx=0.
  - word_valid=0, load_pulse=0, err_invalid=0, sw_echo=0.
  - Both edge-detect registers are set to 1, so a button held through reset does not generate a press.
- Edge detect:
  - ld_e = btn_load & ~btn_load_q; bk_e = btn_back & ~btn_back_q; the _q registers sample the button every cycle.
  - A press is acted on at the same clk edge where the rise is first seen.
  - All outputs are registered: latency is 1 cycle from the sampled rise to the output change.
- sw_echo <= sw_in every cycle (outside reset).
- load_pulse and err_invalid default to 0 each cycle. They are never high together.
- State LOAD (fill_idx < NUM_SYMS):
  - ld_e and sw_in <= MAX_SYM: slot[fill_idx] <= sw_in; fill_idx++; load_pulse=1. If the written slot was NUM_SYMS-1: state<=FULL, word_valid<=1 in the same cycle.
  - ld_e and sw_in > MAX_SYM: no write, no index change, err_invalid=1.
  - bk_e without ld_e and fill_idx>0: fill_idx--; slot[fill_idx-1] <= 0.
  - bk_e at fill_idx==0: ignored, no strobe.
  - ld_e and bk_e in the same cycle: load is processed (valid or invalid); back is dropped.
- State FULL (fill_idx==NUM_SYMS, word_valid=1, word_out stable):
  - ld_e, sw_in not checked: clear all slots, fill_idx<=0, word_valid<=0, load_pulse=1, state<=LOAD. This re-arm press does not load a symbol.
  - bk_e without ld_e: slot[NUM_SYMS-1] <= 0, fill_idx<=NUM_SYMS-1, word_valid<=0, state<=LOAD.
  - Simultaneous ld_e and bk_e: re-arm wins.
- Held button: only one action per rise, regardless of how long the button is held.
- Reset mid-operation: buffer is discarded immediately and word_valid drops at that clock edge.
- Arithmetic:
  - MAX_SYM compare is unsigned, SYM_W wide.
  - fill_idx never exceeds NUM_SYMS and never underflows.
- Slots not yet loaded read as 0 in word_out.

Decomposition:
- Package load_pkg:
  - state enum {LOAD, FULL}.
  - Defaults SYM_W_DEF=5, NUM_SYMS_DEF=4, MAX_SYM_DEF=26.
  - Function for packed slot slicing.
- Sub-module rise_edge_det: parameter RST_VAL (reset value of _q), ports clk, rst, level in, pulse out. Two instances, both RST_VAL=1.

Test Plan:
- Reset with btn_load held high, release, then load 3,0,25,26 on separate rises:
  - No action on the held button.
  - load_pulse 4×; fill_idx 1,2,3,4.
  - word_out={26,25,0,3}; word_valid=1 one cycle after the 4th rise.
- Load 1, then press with sw_in=27 and 31:
  - err_invalid pulses twice; fill_idx stays 1; word_out slot1=0; load_pulse stays 0 for those presses.
- Load 5,6 then btn_back:
  - fill_idx=1, slot1=0.
  - A second back gives fill_idx=0; a third back is ignored with no strobes.
- Fill to FULL then btn_back:
  - word_valid=0, fill_idx=3, slot3=0, the other slots kept.
  - Reloading 9 restores word_valid=1 with slot3=9.
- In FULL, assert btn_load and btn_back on the same cycle:
  - All slots=0, fill_idx=0, load_pulse=1, word_valid=0.
- NUM_SYMS=8, MAX_SYM=9, SYM_W=4: load 0..7 with btn_load held 5 cycles per press:
  - Exactly 8 accepts; word_valid=1.
  - Assert rst mid-fill on a repeat run: all outputs 0 on the next edge.

Source files
------------

// File: rtl/load_pkg.sv
// Shared types, parameter defaults and slot-slicing helper for the word loader.
package load_pkg;

  typedef enum logic {
    LOAD = 1'b0,
    FULL = 1'b1
  } state_t;

  localparam int unsigned SYM_W_DEF    = 5;
  localparam int unsigned NUM_SYMS_DEF = 4;
  localparam int unsigned MAX_SYM_DEF  = 26;

  // Bit offset of slot idx inside a packed word of sym_w-wide slots.
  function automatic int unsigned slot_lo(input int unsigned idx, input int unsigned sym_w);
    return idx * sym_w;
  endfunction

endpackage

// File: rtl/rise_edge_det.sv
// Rising-edge detector: pulse is high in the cycle a level first reads 1.
module rise_edge_det #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic pulse
);

  logic level_q;

  // A reset value of 1 keeps a button held through reset from counting as a press.
  always_ff @(posedge clk) begin
    if (!rst) level_q <= RST_VAL;
    else      level_q <= level;
  end

  assign pulse = level & ~level_q;

endmodule

// File: rtl/load_word_buffer.sv
// Collects NUM_SYMS validated switch symbols, one per button rise, into a packed word.
module load_word_buffer
  import load_pkg::*;
#(
  parameter int unsigned SYM_W    = SYM_W_DEF,
  parameter int unsigned NUM_SYMS = NUM_SYMS_DEF,
  parameter int unsigned MAX_SYM  = MAX_SYM_DEF,
  localparam int unsigned IDX_W   = $clog2(NUM_SYMS + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      btn_load,
  input  logic                      btn_back,
  input  logic [SYM_W-1:0]          sw_in,
  output logic [SYM_W-1:0]          sw_echo,
  output logic [NUM_SYMS*SYM_W-1:0] word_out,
  output logic                      word_valid,
  output logic                      load_pulse,
  output logic                      err_invalid,
  output logic [IDX_W-1:0]          fill_idx
);

  localparam int unsigned WORD_W = NUM_SYMS * SYM_W;
  localparam int unsigned LSB_W  = $clog2(WORD_W);

  if (NUM_SYMS < 2 || NUM_SYMS > 16) begin : g_bad_num
    $error("NUM_SYMS must be in 2..16");
  end
  if (MAX_SYM >= (2 ** SYM_W)) begin : g_bad_max
    $error("MAX_SYM must fit in SYM_W bits");
  end

  state_t           state;
  logic             ld_e;
  logic             bk_e;
  logic             sym_ok;
  logic             last_slot;
  logic             idx_zero;
  logic [LSB_W-1:0] wr_lsb;
  logic [LSB_W-1:0] back_lsb;

  rise_edge_det #(.RST_VAL(1'b1)) u_load_edge (
    .clk   (clk),
    .rst   (rst),
    .level (btn_load),
    .pulse (ld_e)
  );

  rise_edge_det #(.RST_VAL(1'b1)) u_back_edge (
    .clk   (clk),
    .rst   (rst),
    .level (btn_back),
    .pulse (bk_e)
  );

  // Slot addresses for the write and backspace targets.
  always_comb begin
    sym_ok    = (sw_in <= SYM_W'(MAX_SYM));
    last_slot = (fill_idx == IDX_W'(NUM_SYMS - 1));
    idx_zero  = (fill_idx == '0);
    wr_lsb    = LSB_W'(slot_lo(32'(fill_idx), SYM_W));
    back_lsb  = LSB_W'(slot_lo(32'(fill_idx - IDX_W'(1)), SYM_W));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= LOAD;
      word_out    <= '0;
      fill_idx    <= '0;
      word_valid  <= 1'b0;
      load_pulse  <= 1'b0;
      err_invalid <= 1'b0;
      sw_echo     <= '0;
    end else begin
      sw_echo     <= sw_in;
      load_pulse  <= 1'b0;
      err_invalid <= 1'b0;
      case (state)
        LOAD: begin
          if (ld_e) begin
            if (sym_ok) begin
              word_out[wr_lsb +: SYM_W] <= sw_in;
              fill_idx                  <= fill_idx + IDX_W'(1);
              load_pulse                <= 1'b1;
              if (last_slot) begin
                state      <= FULL;
                word_valid <= 1'b1;
              end
            end else begin
              err_invalid <= 1'b1;
            end
          end else if (bk_e && !idx_zero) begin
            word_out[back_lsb +: SYM_W] <= '0;
            fill_idx                    <= fill_idx - IDX_W'(1);
          end
        end
        FULL: begin
          // Re-arm discards the word without consuming the switch value.
          if (ld_e) begin
            word_out   <= '0;
            fill_idx   <= '0;
            word_valid <= 1'b0;
            load_pulse <= 1'b1;
            state      <= LOAD;
          end else if (bk_e) begin
            word_out[back_lsb +: SYM_W] <= '0;
            fill_idx                    <= IDX_W'(NUM_SYMS - 1);
            word_valid                  <= 1'b0;
            state                       <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_load_word_buffer.sv
// Bench for load_word_buffer: default and 8x4-bit instances against a slot-list model.
module tb_load_word_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_a, bk_a, ld_b, bk_b;
  logic [4:0]  sw_a, echo_a;
  logic [3:0]  sw_b, echo_b;
  logic [19:0] word_a;
  logic [31:0] word_b;
  logic        valid_a, pulse_a, err_a, valid_b, pulse_b, err_b;
  logic [2:0]  fill_a;
  logic [3:0]  fill_b;

  int n_vec = 0;
  int n_err = 0;
  int pa = 0, ea = 0, pb = 0;
  bit armed = 1'b0;

  // Model: per instance a count of filled slots and the symbol list.
  int n     [2];
  int sym   [2][16];
  bit pld   [2];
  bit pbk   [2];
  bit epul  [2];
  bit eerr  [2];
  int eecho [2];

  always #5 clk = ~clk;

  load_word_buffer dut_a (
    .clk(clk), .rst(rst), .btn_load(ld_a), .btn_back(bk_a), .sw_in(sw_a),
    .sw_echo(echo_a), .word_out(word_a), .word_valid(valid_a),
    .load_pulse(pulse_a), .err_invalid(err_a), .fill_idx(fill_a)
  );

  load_word_buffer #(.SYM_W(4), .NUM_SYMS(8), .MAX_SYM(9)) dut_b (
    .clk(clk), .rst(rst), .btn_load(ld_b), .btn_back(bk_b), .sw_in(sw_b),
    .sw_echo(echo_b), .word_out(word_b), .word_valid(valid_b),
    .load_pulse(pulse_b), .err_invalid(err_b), .fill_idx(fill_b)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mstep(input int k, input bit r, input bit ld, input bit bk,
                       input int sw, input int num, input int maxs);
    bit lr, br;
    if (!r) begin
      n[k] = 0;
      for (int i = 0; i < 16; i++) sym[k][i] = 0;
      pld[k] = 1'b1; pbk[k] = 1'b1;
      epul[k] = 1'b0; eerr[k] = 1'b0; eecho[k] = 0;
      return;
    end
    lr = ld && !pld[k];
    br = bk && !pbk[k];
    pld[k] = ld; pbk[k] = bk;
    epul[k] = 1'b0; eerr[k] = 1'b0; eecho[k] = sw;
    if (lr) begin
      if (n[k] == num) begin
        for (int i = 0; i < 16; i++) sym[k][i] = 0;
        n[k] = 0;
        epul[k] = 1'b1;
      end else if (sw <= maxs) begin
        sym[k][n[k]] = sw;
        n[k]++;
        epul[k] = 1'b1;
      end else begin
        eerr[k] = 1'b1;
      end
    end else if (br && n[k] > 0) begin
      n[k]--;
      sym[k][n[k]] = 0;
    end
  endtask

  function automatic logic [63:0] pack(input int k, input int num, input int w);
    logic [63:0] r = '0;
    for (int i = 0; i < num; i++) r = r | (64'(sym[k][i]) << (i * w));
    return r;
  endfunction

  always @(posedge clk) begin
    mstep(0, rst, ld_a, bk_a, int'(sw_a), 4, 26);
    mstep(1, rst, ld_b, bk_b, int'(sw_b), 8, 9);
    armed = 1'b1;
  end

  always @(posedge clk) begin
    #2;
    if (pulse_a) pa++;
    if (err_a)   ea++;
    if (pulse_b) pb++;
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("a_word",  64'(word_a),  pack(0, 4, 5));
      chk("a_valid", 64'(valid_a), 64'(n[0] == 4));
      chk("a_fill",  64'(fill_a),  64'(n[0]));
      chk("a_pulse", 64'(pulse_a), 64'(epul[0]));
      chk("a_err",   64'(err_a),   64'(eerr[0]));
      chk("a_echo",  64'(echo_a),  64'(eecho[0]));
      chk("b_word",  64'(word_b),  pack(1, 8, 4));
      chk("b_valid", 64'(valid_b), 64'(n[1] == 8));
      chk("b_fill",  64'(fill_b),  64'(n[1]));
      chk("b_pulse", 64'(pulse_b), 64'(epul[1]));
      chk("b_err",   64'(err_b),   64'(eerr[1]));
      chk("b_echo",  64'(echo_b),  64'(eecho[1]));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic press_a(input int sw, input int hold);
    sw_a = 5'(sw); ld_a = 1'b1;
    repeat (hold) tick();
    ld_a = 1'b0;
    tick();
  endtask

  task automatic back_a();
    bk_a = 1'b1; tick();
    bk_a = 1'b0; tick();
  endtask

  task automatic press_b(input int sw, input int hold);
    sw_b = 4'(sw); ld_b = 1'b1;
    repeat (hold) tick();
    ld_b = 1'b0;
    tick();
  endtask

  initial begin
    int p0, e0;
    rst = 1'b0; ld_a = 1'b1; bk_a = 1'b0; sw_a = 5'd7;
    ld_b = 1'b0; bk_b = 1'b0; sw_b = 4'd0;
    repeat (3) tick();
    chk("rst_fill", 64'(fill_a), 64'd0);
    chk("rst_echo", 64'(echo_a), 64'd0);
    rst = 1'b1;
    repeat (2) tick();
    chk("held_fill", 64'(fill_a), 64'd0);
    chk("held_pulses", 64'(pa), 64'd0);
    ld_a = 1'b0; tick();

    p0 = pa;
    press_a(3, 1); chk("fill1", 64'(fill_a), 64'd1);
    press_a(0, 1); chk("fill2", 64'(fill_a), 64'd2);
    press_a(25, 1); chk("fill3", 64'(fill_a), 64'd3);
    press_a(26, 1);
    chk("fill4", 64'(fill_a), 64'd4);
    chk("full_valid", 64'(valid_a), 64'd1);
    chk("full_word", 64'(word_a), 64'({5'd26, 5'd25, 5'd0, 5'd3}));
    chk("four_pulses", 64'(pa - p0), 64'd4);

    press_a(0, 1);
    chk("rearm_fill", 64'(fill_a), 64'd0);
    p0 = pa; e0 = ea;
    press_a(1, 1); press_a(27, 1); press_a(31, 1);
    chk("inv_errs", 64'(ea - e0), 64'd2);
    chk("inv_pulses", 64'(pa - p0), 64'd1);
    chk("inv_fill", 64'(fill_a), 64'd1);
    chk("inv_word", 64'(word_a), 64'd1);

    back_a();
    press_a(5, 1); press_a(6, 1);
    back_a();
    chk("bk_fill", 64'(fill_a), 64'd1);
    chk("bk_word", 64'(word_a), 64'd5);
    p0 = pa; e0 = ea;
    back_a(); back_a();
    chk("bk_empty", 64'(fill_a), 64'd0);
    chk("bk_strobes", 64'((pa - p0) + (ea - e0)), 64'd0);

    press_a(1, 1); press_a(2, 1); press_a(3, 1); press_a(4, 1);
    back_a();
    chk("fullbk_valid", 64'(valid_a), 64'd0);
    chk("fullbk_fill", 64'(fill_a), 64'd3);
    chk("fullbk_word", 64'(word_a), 64'({5'd0, 5'd3, 5'd2, 5'd1}));
    press_a(9, 1);
    chk("reload_word", 64'(word_a), 64'({5'd9, 5'd3, 5'd2, 5'd1}));
    chk("reload_valid", 64'(valid_a), 64'd1);

    p0 = pa;
    ld_a = 1'b1; bk_a = 1'b1; tick();
    ld_a = 1'b0; bk_a = 1'b0; tick();
    chk("both_word", 64'(word_a), 64'd0);
    chk("both_fill", 64'(fill_a), 64'd0);
    chk("both_valid", 64'(valid_a), 64'd0);
    chk("both_pulse", 64'(pa - p0), 64'd1);

    for (int c = 0; c < 1500; c++) begin
      rst  = ($urandom % 97) != 0;
      ld_a = ($urandom % 3) == 0;
      bk_a = ($urandom % 5) == 0;
      sw_a = 5'($urandom);
      ld_b = ($urandom % 3) == 0;
      bk_b = ($urandom % 6) == 0;
      sw_b = 4'($urandom_range(0, 11));
      tick();
    end
    rst = 1'b1; ld_a = 1'b0; bk_a = 1'b0; ld_b = 1'b0; bk_b = 1'b0;
    tick();

    rst = 1'b0; repeat (2) tick(); rst = 1'b1; tick();
    p0 = pb;
    for (int s = 0; s < 8; s++) press_b(s, 5);
    chk("b8_pulses", 64'(pb - p0), 64'd8);
    chk("b8_valid", 64'(valid_b), 64'd1);
    chk("b8_word", 64'(word_b), 64'h76543210);
    press_b(0, 5);
    for (int s = 0; s < 4; s++) press_b(s + 2, 5);
    chk("b4_fill", 64'(fill_b), 64'd4);
    sw_b = 4'd9; rst = 1'b0; tick();
    chk("brst_fill", 64'(fill_b), 64'd0);
    chk("brst_word", 64'(word_b), 64'd0);
    chk("brst_valid", 64'(valid_b), 64'd0);
    chk("brst_echo", 64'(echo_b), 64'd0);
    rst = 1'b1; repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
